bcd_to_bin_seq: RTL

- Sequential multi-digit packed-BCD to binary converter using reverse double-dabble: shift right one bit per cycle, then subtract 3 from every BCD digit that is >= 8.
- Inverse companion to the BCD-output multiply path in the bcd_math library.
- Feeds binary-domain arithmetic from BCD sources through valid/ready handshakes on both sides.

---
 rtl/bcd_math_pkg.sv | 19 +
 rtl/bcd_to_bin_seq_if.sv | 23 ++
 rtl/bcd_digit_sub3.sv | 9 +
 rtl/bcd_to_bin_seq.sv | 129 ++++++++++++
 4 files changed

// File: rtl/bcd_math_pkg.sv
// Shared BCD types, thresholds and helpers for the reverse double-dabble converters.
package bcd_math_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;

   localparam bcd_digit_t BCD_MAX_DIGIT  = 4'd9;
   localparam bcd_digit_t BCD_ADJ_THRESH = 4'd8;

   function automatic logic bcd_digit_illegal(input bcd_digit_t d);
      return d > BCD_MAX_DIGIT;
   endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Valid/ready handshake bundle for the BCD-to-binary converter: BCD word in, binary result out.
interface bcd_to_bin_seq_if #(
   parameter int DIGITS    = 4,
   parameter int BIN_WIDTH = 14
);
   logic                   data_valid;
   logic                   data_ready;
   logic [4*DIGITS-1:0]    dataa;
   logic                   result_valid;
   logic                   result_ready;
   logic [BIN_WIDTH-1:0]   result;
   logic                   error;

   modport master (
      output data_valid, dataa, result_ready,
      input  data_ready, result_valid, result, error
   );

   modport slave (
      input  data_valid, dataa, result_ready,
      output data_ready, result_valid, result, error
   );
endinterface

// File: rtl/bcd_digit_sub3.sv
// One reverse double-dabble correction: a digit that reached 8 or more after the shift loses 3.
import bcd_math_pkg::*;

module bcd_digit_sub3 (
   input  bcd_digit_t din,
   output bcd_digit_t dout
);
   assign dout = (din >= BCD_ADJ_THRESH) ? din - 4'd3 : din;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter, one reverse double-dabble step per clock.
//
// state | meaning
// IDLE  | data_ready high, waiting for a BCD word
// SHIFT | BIN_WIDTH shift+adjust steps on the work register
// DONE  | result_valid high, holding result/error until result_ready
import bcd_math_pkg::*;

module bcd_to_bin_seq #(
   parameter int DIGITS    = 4,
   parameter int BIN_WIDTH = 14
) (
   input logic             clock,
   input logic             clock_sreset,
   bcd_to_bin_seq_if.slave bus
);
   localparam int W     = 4*DIGITS + BIN_WIDTH;
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);

   if ((64'd1 << BIN_WIDTH) <= (64'd10 ** DIGITS) - 64'd1) begin : g_width_check
      $error("bcd_to_bin_seq: BIN_WIDTH cannot hold 10**DIGITS-1");
   end

   conv_state_t            state_q, state_d;
   logic [W-1:0]           work_q, work_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic [BIN_WIDTH-1:0]   result_q, result_d;
   logic                   error_q, error_d;
   logic                   rv_q, rv_d;
   logic                   dr_q, dr_d;

   logic [W-1:0]           shifted;
   logic [W-1:0]           adjusted;
   logic [4*DIGITS-1:0]    adj_field;
   logic [DIGITS-1:0]      illegal_vec;

   assign shifted = work_q >> 1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_sub3 u_sub3 (
         .din  (shifted[BIN_WIDTH + 4*g +: 4]),
         .dout (adj_field[4*g +: 4])
      );
      assign illegal_vec[g] = bcd_digit_illegal(bus.dataa[4*g +: 4]);
   end

   assign adjusted = {adj_field, shifted[BIN_WIDTH-1:0]};

   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      result_d = result_q;
      error_d  = error_q;
      rv_d     = rv_q;
      dr_d     = dr_q;
      case (state_q)
         IDLE: begin
            dr_d = 1'b1;
            if (bus.data_valid && dr_q) begin
               work_d  = {bus.dataa, {BIN_WIDTH{1'b0}}};
               err_d   = |illegal_vec;
               cnt_d   = '0;
               dr_d    = 1'b0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            work_d = adjusted;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
               result_d = err_q ? '0 : adjusted[BIN_WIDTH-1:0];
               error_d  = err_q;
               rv_d     = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (bus.result_ready) begin
               rv_d    = 1'b0;
               dr_d    = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            rv_d    = 1'b0;
            dr_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (clock_sreset) begin
         state_q  <= IDLE;
         work_q   <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         result_q <= '0;
         error_q  <= 1'b0;
         rv_q     <= 1'b0;
         dr_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         result_q <= result_d;
         error_q  <= error_d;
         rv_q     <= rv_d;
         dr_q     <= dr_d;
      end
   end

   assign bus.data_ready   = dr_q;
   assign bus.result_valid = rv_q;
   assign bus.result       = result_q;
   assign bus.error        = error_q;

   // A legal word is fully drained out of the BCD field by the last step.
   always_ff @(posedge clock) begin
      if (!clock_sreset && state_q == DONE && !error_q) begin
         assert (work_q[W-1:BIN_WIDTH] == '0)
            else $error("bcd_to_bin_seq: BCD field not empty after conversion");
      end
   end
endmodule
